mem_arbiter: RTL

Single-port memory arbiter between the instruction-fetch port and the load/store port of the RISC-V core. It grants one outstanding transaction at a time to a fixed-latency memory and steers the read data back to the owner. It also generates byte enables and write-data lanes from the load/store size encoding that the control unit produces (`memSize`: 00 byte, 01 half, 10 word). Data requests have priority over fetch, and a starvation limit bounds how long fetch can be held off.

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares a single fixed-latency memory port between instruction fetch and
//   load/store. Only one transaction is outstanding at a time. Data requests
//   take priority over fetch, and a starvation counter lets fetch win after
//   STARVE_LIMIT consecutive data grants while fetch is waiting. Byte enables
//   and lane-replicated write data are built from the load/store size code.
//
//   Optional feature macro: MEM_ARB_MISALIGN_TRAP_EN
//     defined   : misaligned half/word data accesses are granted without a
//                 memory strobe and answered with a d_err pulse.
//     undefined : misaligned low address bits are ignored, d_err is tied 0.
//
// Parameters
//   MEM_LATENCY  : grant-to-rdata cycles (1..4)
//   STARVE_LIMIT : max consecutive data grants while fetch waits (1..15)
// Ports
//   clk, rst_n                     : clock, async active-low reset
//   if_req/if_addr/if_gnt          : fetch request handshake
//   if_rvalid/if_rdata             : fetch response pulse and word
//   d_req/d_we/d_addr/d_wdata/d_size/d_gnt : load/store request handshake
//   d_rvalid/d_rdata/d_err         : load response, misalign error pulse
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata/mem_rdata : memory port
//   busy                           : a transaction is outstanding
module mem_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [3:0]  starve_cnt;
  logic        own_d;    // owner of outstanding transaction: 1 data, 0 fetch
  logic        own_we;   // outstanding data transaction is a store
  logic        own_err;  // outstanding data transaction was trapped

  logic        free, rsp, starve_hit, pick_f, pick_d;
  logic        gnt_f, gnt_d, issue_d;
  logic [3:0]  d_be;
  logic [31:0] d_wd;
  logic        d_trap;

  assign free       = (state == IDLE) || (cnt == 3'd1);
  assign rsp        = (state == WAIT) && (cnt == 3'd1);
  assign starve_hit = (starve_cnt == STARVE_LIMIT[3:0]);

  // Fetch overrides data only once the starvation limit is reached.
  assign pick_f = if_req && (!d_req || starve_hit);
  assign pick_d = d_req && !pick_f;

  // Grants are gated by rst_n so nothing leaks out while reset is held.
  assign gnt_f = rst_n && free && pick_f;
  assign gnt_d = rst_n && free && pick_d;

  // Lane steering. mem_addr is always word aligned, so dropping addr[0] for
  // halves and addr[1:0] for words falls out of the be/address encoding.
  always_comb begin
    d_be   = 4'b1111;
    d_wd   = d_wdata;
    d_trap = 1'b0;
    case (d_size)
      2'b00: begin
        d_be = 4'b0001 << d_addr[1:0];
        d_wd = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        d_be = 4'b0011 << {d_addr[1], 1'b0};
        d_wd = {2{d_wdata[15:0]}};
`ifdef MEM_ARB_MISALIGN_TRAP_EN
        d_trap = d_addr[0];
`endif
      end
      default: begin
`ifdef MEM_ARB_MISALIGN_TRAP_EN
        d_trap = |d_addr[1:0];
`endif
      end
    endcase
  end

  // A trapped data request is granted but never reaches memory.
  assign issue_d   = gnt_d && !d_trap;
  assign mem_req   = gnt_f || issue_d;
  assign mem_we    = issue_d && d_we;
  assign mem_addr  = gnt_f   ? (if_addr & 32'hFFFF_FFFC) :
                     issue_d ? (d_addr  & 32'hFFFF_FFFC) : 32'h0;
  assign mem_be    = gnt_f ? 4'b1111 : (issue_d ? d_be : 4'b0000);
  assign mem_wdata = mem_we ? d_wd : 32'h0;

  assign if_gnt    = gnt_f;
  assign d_gnt     = gnt_d;
  assign busy      = (state == WAIT);
  assign if_rvalid = rsp && !own_d;
  assign d_rvalid  = rsp && own_d && !own_we && !own_err;
  assign if_rdata  = rst_n ? mem_rdata : 32'h0;
  assign d_rdata   = rst_n ? mem_rdata : 32'h0;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
  assign d_err     = rsp && own_d && own_err;
`else
  assign d_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      starve_cnt <= 4'd0;
      own_d      <= 1'b0;
      own_we     <= 1'b0;
      own_err    <= 1'b0;
    end else begin
      if (gnt_f || gnt_d) begin
        state   <= WAIT;
        cnt     <= MEM_LATENCY[2:0];
        own_d   <= gnt_d;
        own_we  <= gnt_d && d_we;
        own_err <= gnt_d && d_trap;
      end else if (free) begin
        state <= IDLE;
        cnt   <= 3'd0;
      end else begin
        cnt <= cnt - 3'd1;
      end

      if (!if_req || gnt_f)
        starve_cnt <= 4'd0;
      else if (gnt_d && !starve_hit)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule
